// File: rtl/egg_drop_run_ctrl.sv
// egg_drop_run_ctrl: boots the egg-drop core, watches its PC for halt
// or budget timeout, and freezes the core's results for the host side.
module egg_drop_run_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned HALT_WINDOW = 8,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        ack_i,
  input  logic [31:0] floors_i,
  input  logic [31:0] resistance_i,
  output logic        cpu_rst_o,
  output logic [31:0] init_floors_o,
  output logic [31:0] init_resistance_o,
  input  logic [31:0] cpu_pc_i,
  input  logic [31:0] cpu_attempt_i,
  input  logic [31:0] cpu_broken_i,
  input  logic [31:0] cpu_cost_f1_i,
  input  logic [31:0] cpu_cost_f2_i,
  input  logic        cpu_last_broken_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycles_o,
  output logic [31:0] res_attempt_o,
  output logic [31:0] res_broken_o,
  output logic [31:0] res_cost_f1_o,
  output logic [31:0] res_cost_f2_o,
  output logic        res_last_broken_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BOOT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] HALT_LAST = 32'(HALT_WINDOW - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] boot_cnt;
  logic [31:0] cyc_cnt;
  logic [31:0] same_cnt;
  logic [31:0] pc_prev;
  logic        first;

  logic        pc_same;
  logic        halt_hit;
  logic        to_hit;
  logic        capture;
  logic [31:0] cyc_inc;

  // first suppresses the compare against the stale pc_prev on entry to RUN
  assign pc_same  = !first && (cpu_pc_i == pc_prev);
  assign halt_hit = (state == S_RUN) && pc_same && (same_cnt == HALT_LAST);
  assign to_hit   = (state == S_RUN) && (cyc_cnt == TO_LAST);
  assign capture  = halt_hit || to_hit;
  assign cyc_inc  = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

  assign cpu_rst_o = (state == S_IDLE) || (state == S_BOOT);
  assign busy_o    = (state == S_BOOT) || (state == S_RUN);
  assign done_o    = (state == S_DONE);

  // run sequencing: boot window, PC-stability tracking, cycle budget
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      boot_cnt <= '0;
      cyc_cnt  <= '0;
      same_cnt <= '0;
      pc_prev  <= '0;
      first    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_BOOT;
            boot_cnt <= '0;
          end
        end
        S_BOOT: begin
          boot_cnt <= boot_cnt + 32'd1;
          if (boot_cnt == BOOT_LAST) begin
            state    <= S_RUN;
            cyc_cnt  <= '0;
            same_cnt <= '0;
            first    <= 1'b1;
          end
        end
        S_RUN: begin
          pc_prev  <= cpu_pc_i;
          cyc_cnt  <= cyc_inc;
          same_cnt <= pc_same ? same_cnt + 32'd1 : '0;
          first    <= 1'b0;
          if (capture) state <= S_DONE;
        end
        S_DONE: begin
          if (ack_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // core init parameters, latched only when a run is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_floors_o     <= '0;
      init_resistance_o <= '0;
    end else if (state == S_IDLE && start_i) begin
      init_floors_o     <= floors_i;
      init_resistance_o <= resistance_i;
    end
  end

  // result bank, overwritten only on capture; halt outranks timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_o         <= 1'b0;
      cycles_o          <= '0;
      res_attempt_o     <= '0;
      res_broken_o      <= '0;
      res_cost_f1_o     <= '0;
      res_cost_f2_o     <= '0;
      res_last_broken_o <= 1'b0;
    end else if (capture) begin
      timeout_o         <= !halt_hit;
      cycles_o          <= cyc_cnt + 32'd1;
      res_attempt_o     <= cpu_attempt_i;
      res_broken_o      <= cpu_broken_i;
      res_cost_f1_o     <= cpu_cost_f1_i;
      res_cost_f2_o     <= cpu_cost_f2_i;
      res_last_broken_o <= cpu_last_broken_i;
    end
  end

endmodule

// File: tb/tb_egg_drop_run_ctrl.sv
// tb_egg_drop_run_ctrl: scoreboard bench for the egg-drop run controller.
// Expected captures are queued at start and popped when done_o rises.
module tb_egg_drop_run_ctrl;

  logic        clk;
  logic        clk_go;
  logic        rst_i;
  logic        start_i;
  logic        ack_i;
  logic [31:0] floors_i;
  logic [31:0] resistance_i;
  logic        cpu_rst_o;
  logic [31:0] init_floors_o;
  logic [31:0] init_resistance_o;
  logic [31:0] cpu_pc_i;
  logic [31:0] cpu_attempt_i;
  logic [31:0] cpu_broken_i;
  logic [31:0] cpu_cost_f1_i;
  logic [31:0] cpu_cost_f2_i;
  logic        cpu_last_broken_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic [31:0] cycles_o;
  logic [31:0] res_attempt_o;
  logic [31:0] res_broken_o;
  logic [31:0] res_cost_f1_o;
  logic [31:0] res_cost_f2_o;
  logic        res_last_broken_o;

  egg_drop_run_ctrl #(
    .BOOT_CYCLES(4),
    .HALT_WINDOW(8),
    .TIMEOUT(50)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .start_i(start_i),
    .ack_i(ack_i),
    .floors_i(floors_i),
    .resistance_i(resistance_i),
    .cpu_rst_o(cpu_rst_o),
    .init_floors_o(init_floors_o),
    .init_resistance_o(init_resistance_o),
    .cpu_pc_i(cpu_pc_i),
    .cpu_attempt_i(cpu_attempt_i),
    .cpu_broken_i(cpu_broken_i),
    .cpu_cost_f1_i(cpu_cost_f1_i),
    .cpu_cost_f2_i(cpu_cost_f2_i),
    .cpu_last_broken_i(cpu_last_broken_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .timeout_o(timeout_o),
    .cycles_o(cycles_o),
    .res_attempt_o(res_attempt_o),
    .res_broken_o(res_broken_o),
    .res_cost_f1_o(res_cost_f1_o),
    .res_cost_f2_o(res_cost_f2_o),
    .res_last_broken_o(res_last_broken_o)
  );

  typedef struct {
    logic [31:0] cyc;
    logic        to;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c1;
    logic [31:0] c2;
    logic        lb;
  } exp_t;

  exp_t sb[$];

  int n_chk;
  int n_pass;

  logic [31:0] prev_att;

  initial begin
    clk = 1'b0;
    @(posedge clk_go);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // PC model per run style, k = RUN cycle index
  function automatic logic [31:0] pc_of(input int mode, input int k);
    case (mode)
      0:       return (k < 20) ? 32'(4 * k) : 32'h50;
      1:       return 32'(4 * ((k + 1) / 2));
      2:       return 32'(4 * k);
      default: return (k <= 41) ? 32'(4 * k) : 32'd164;
    endcase
  endfunction

  task automatic do_run(input int mode,
                        input logic [31:0] fl,
                        input logic [31:0] rs,
                        input logic [31:0] e_cyc,
                        input logic e_to,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] c1,
                        input logic [31:0] c2,
                        input logic lb);
    exp_t e;
    exp_t g;
    bit   seen;
    e.cyc = e_cyc; e.to = e_to;
    e.a = a; e.b = b; e.c1 = c1; e.c2 = c2; e.lb = lb;
    sb.push_back(e);
    @(negedge clk);
    floors_i = fl;
    resistance_i = rs;
    cpu_attempt_i = a;
    cpu_broken_i = b;
    cpu_cost_f1_i = c1;
    cpu_cost_f2_i = c2;
    cpu_last_broken_i = lb;
    cpu_pc_i = 32'h0;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    check("init_floors", init_floors_o, fl);
    check("init_res", init_resistance_o, rs);
    check("busy_boot", 32'(busy_o), 32'd1);
    check("res_held_boot", res_attempt_o, prev_att);
    repeat (3) @(posedge clk);
    #1 check("cpu_rst_e3", 32'(cpu_rst_o), 32'd1);
    @(posedge clk);
    #1 check("cpu_rst_e4", 32'(cpu_rst_o), 32'd0);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cpu_pc_i = pc_of(mode, k);
      @(posedge clk);
      #1;
      if (mode == 1 && k == 10) check("busy_stall", 32'(busy_o), 32'd1);
      if (done_o) begin
        seen = 1;
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          g = sb.pop_front();
          check("cycles", cycles_o, g.cyc);
          check("timeout", 32'(timeout_o), 32'(g.to));
          check("res_att", res_attempt_o, g.a);
          check("res_brk", res_broken_o, g.b);
          check("res_f1", res_cost_f1_o, g.c1);
          check("res_f2", res_cost_f2_o, g.c2);
          check("res_lb", 32'(res_last_broken_o), 32'(g.lb));
          check("done_busy", 32'(busy_o), 32'd0);
          prev_att = g.a;
        end
      end
    end
    if (!seen) check("done_wait", 32'd0, 32'd1);
    // results stay frozen in DONE while the core keeps running
    cpu_attempt_i = 32'hDEAD;
    start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 start_i = 1'b0;
    check("done_hold", 32'(done_o), 32'd1);
    check("done_frozen", res_attempt_o, prev_att);
    check("done_cpu_rst", 32'(cpu_rst_o), 32'd0);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack_i = 1'b1;
    @(posedge clk);
    #1 ack_i = 1'b0;
    check("ack_done", 32'(done_o), 32'd0);
    check("ack_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("ack_busy", 32'(busy_o), 32'd0);
    check("ack_held", res_attempt_o, prev_att);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    prev_att = 32'd0;
    clk_go = 1'b0;
    rst_i = 1'b1;
    start_i = 1'b0;
    ack_i = 1'b0;
    floors_i = 32'd0;
    resistance_i = 32'd0;
    cpu_pc_i = 32'd0;
    cpu_attempt_i = 32'd0;
    cpu_broken_i = 32'd0;
    cpu_cost_f1_i = 32'd0;
    cpu_cost_f2_i = 32'd0;
    cpu_last_broken_i = 1'b0;
    #2;
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_cycles", cycles_o, 32'd0);
    check("rst_res", res_attempt_o | res_broken_o | res_cost_f1_o
          | res_cost_f2_o | 32'(res_last_broken_o), 32'd0);
    #3 rst_i = 1'b0;
    #5 clk_go = 1'b1;
    repeat (2) @(posedge clk);

    do_run(0, 32'd100, 32'd14, 32'd29, 1'b0, 32'd7, 32'd2, 32'd9, 32'd11, 1'b1);
    do_ack();
    do_run(1, 32'd36, 32'd5, 32'd50, 1'b1, 32'd3, 32'd1, 32'd5, 32'd6, 1'b0);
    do_ack();
    do_run(2, 32'd20, 32'd2, 32'd50, 1'b1, 32'd4, 32'd4, 32'd8, 32'd12, 1'b1);
    do_ack();
    do_run(3, 32'd64, 32'd9, 32'd50, 1'b0, 32'd6, 32'd3, 32'd1, 32'd2, 1'b0);
    do_ack();

    // abandon a run with an asynchronous reset between edges
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 cpu_pc_i = 32'(4 * k);
    end
    check("pre_rst_run", 32'(cpu_rst_o), 32'd0);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("arst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_res", res_attempt_o, 32'd0);
    check("arst_cycles", cycles_o, 32'd0);
    check("arst_init", init_floors_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    cpu_pc_i = 32'h80;
    repeat (60) @(posedge clk);
    #1;
    check("arst_idle", 32'(done_o), 32'd0);
    check("arst_nocap", cycles_o, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
